// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter
//   Central PCI bus arbiter for up to 8 initiators. Samples active-low REQ_N,
//   drives a registered one-cold GNT_N with round-robin priority, tracks bus
//   ownership from FRAME_N/IRDY_N, revokes grants that go unused for TIMEOUT
//   idle cycles and optionally parks the bus on PARK_ID when nobody requests.
//
// Ports
//   CLK          in   bus clock, rising edge
//   RST          in   synchronous reset, active high
//   REQ_N        in   [N_MASTERS-1:0] requests, active low
//   FRAME_N      in   bus FRAME#, active low
//   IRDY_N       in   bus IRDY#, active low
//   GNT_N        out  [N_MASTERS-1:0] grants, active low, at most one low
//   OWNER        out  [2:0] current bus owner index (valid with OWNER_VLD)
//   OWNER_VLD    out  owner's transaction in progress
//   TIMEOUT_EVT  out  one-cycle pulse when a grant is revoked by timeout
//
// Master indices are 3 bits wide, so N_MASTERS must not exceed 8.

module pci_bus_arbiter #(
  parameter int unsigned N_MASTERS = 8,
  parameter int unsigned TIMEOUT   = 16,
  parameter bit          PARK_EN   = 1'b1,
  parameter int unsigned PARK_ID   = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_MASTERS-1:0] REQ_N,
  input  logic                 FRAME_N,
  input  logic                 IRDY_N,
  output logic [N_MASTERS-1:0] GNT_N,
  output logic [2:0]           OWNER,
  output logic                 OWNER_VLD,
  output logic                 TIMEOUT_EVT
);

  localparam int unsigned CW   = $clog2(TIMEOUT + 1);
  localparam logic [2:0]  PARK = 3'(PARK_ID);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_BUS_OWNED,
    S_GAP
  } state_t;

  state_t                 r_state,       w_state_nxt;
  logic [N_MASTERS-1:0]   r_gnt_n,       w_gnt_n_nxt;
  logic [2:0]             r_owner,       w_owner_nxt;
  logic                   r_owner_vld,   w_owner_vld_nxt;
  logic                   r_timeout_evt, w_timeout_evt_nxt;
  logic [2:0]             r_last_owner,  w_last_owner_nxt;
  logic [2:0]             r_granted,     w_granted_nxt;
  logic [CW-1:0]          r_cnt,         w_cnt_nxt;
  logic                   r_idle_d;

  logic                   w_bus_idle;
  logic                   w_any_req;
  logic [2:0]             w_winner;
  logic [N_MASTERS-1:0]   w_win_cold;
  logic [N_MASTERS-1:0]   w_park_cold;
  logic [N_MASTERS-1:0]   w_others;
  logic                   w_other_req;
  logic                   w_parked;

  assign w_bus_idle = FRAME_N & IRDY_N;

  // Round-robin search starting just after the last owner; the last owner
  // itself is examined last.
  always_comb begin
    int unsigned idx;
    w_any_req = 1'b0;
    w_winner  = '0;
    for (int unsigned i = 1; i <= N_MASTERS; i++) begin
      idx = (r_last_owner + i) % N_MASTERS;
      if (!w_any_req && !REQ_N[3'(idx)]) begin
        w_any_req = 1'b1;
        w_winner  = 3'(idx);
      end
    end
  end

  always_comb begin
    w_win_cold            = '1;
    w_win_cold[w_winner]  = 1'b0;
    w_park_cold           = '1;
    w_park_cold[PARK]     = 1'b0;
    w_others              = ~REQ_N;
    w_others[r_owner]     = 1'b0;
    w_other_req           = |w_others;
    w_parked              = PARK_EN && !r_gnt_n[PARK];
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_gnt_n_nxt       = r_gnt_n;
    w_owner_nxt       = r_owner;
    w_owner_vld_nxt   = r_owner_vld;
    w_timeout_evt_nxt = 1'b0;
    w_last_owner_nxt  = r_last_owner;
    w_granted_nxt     = r_granted;
    w_cnt_nxt         = r_cnt;

    unique case (r_state)
      S_IDLE: begin
        if (w_parked && !FRAME_N) begin
          // Parked master started a cycle without requesting; parking is not
          // an arbitration win, so priority history is left untouched.
          w_state_nxt     = S_BUS_OWNED;
          w_owner_nxt     = PARK;
          w_owner_vld_nxt = 1'b1;
          w_granted_nxt   = PARK;
        end else if (w_any_req) begin
          if (w_parked && (w_winner != PARK)) begin
            // Moving the grant away from the park master needs a dead cycle.
            w_gnt_n_nxt = '1;
            w_state_nxt = S_GAP;
          end else begin
            w_gnt_n_nxt   = w_win_cold;
            w_granted_nxt = w_winner;
            w_cnt_nxt     = '0;
            w_state_nxt   = S_GRANT;
          end
        end else begin
          w_gnt_n_nxt = PARK_EN ? w_park_cold : '1;
        end
      end

      S_GRANT: begin
        if (!FRAME_N && r_idle_d) begin
          w_state_nxt      = S_BUS_OWNED;
          w_owner_nxt      = r_granted;
          w_owner_vld_nxt  = 1'b1;
          w_last_owner_nxt = r_granted;
        end else if (REQ_N[r_granted]) begin
          w_gnt_n_nxt = '1;
          w_state_nxt = S_GAP;
        end else if (w_bus_idle && (r_cnt == CW'(TIMEOUT - 1))) begin
          w_gnt_n_nxt       = '1;
          w_timeout_evt_nxt = 1'b1;
          w_last_owner_nxt  = r_granted;
          w_state_nxt       = S_GAP;
        end else if (w_bus_idle) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_BUS_OWNED: begin
        if (REQ_N[r_owner] || w_other_req) begin
          w_gnt_n_nxt = '1;
          w_state_nxt = S_GAP;
        end
      end

      S_GAP: begin
        w_gnt_n_nxt = '1;
        if (w_bus_idle) begin
          w_owner_vld_nxt = 1'b0;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_gnt_n_nxt = '1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_gnt_n       <= '1;
      r_owner       <= '0;
      r_owner_vld   <= 1'b0;
      r_timeout_evt <= 1'b0;
      r_last_owner  <= 3'(N_MASTERS - 1);
      r_granted     <= '0;
      r_cnt         <= '0;
      r_idle_d      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_gnt_n       <= w_gnt_n_nxt;
      r_owner       <= w_owner_nxt;
      r_owner_vld   <= w_owner_vld_nxt;
      r_timeout_evt <= w_timeout_evt_nxt;
      r_last_owner  <= w_last_owner_nxt;
      r_granted     <= w_granted_nxt;
      r_cnt         <= w_cnt_nxt;
      r_idle_d      <= w_bus_idle;
    end
  end

  assign GNT_N       = r_gnt_n;
  assign OWNER       = r_owner;
  assign OWNER_VLD   = r_owner_vld;
  assign TIMEOUT_EVT = r_timeout_evt;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
module tb_pci_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] REQ_N;
  logic       FRAME_N;
  logic       IRDY_N;
  logic [7:0] GNT_N;
  logic [2:0] OWNER;
  logic       OWNER_VLD;
  logic       TIMEOUT_EVT;
  logic [7:0] w_gnt_n_np;
  logic [2:0] w_owner_np;
  logic       w_owner_vld_np;
  logic       w_timeout_evt_np;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  pci_bus_arbiter #(
    .N_MASTERS(8),
    .TIMEOUT  (16),
    .PARK_EN  (1'b1),
    .PARK_ID  (0)
  ) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_N      (REQ_N),
    .FRAME_N    (FRAME_N),
    .IRDY_N     (IRDY_N),
    .GNT_N      (GNT_N),
    .OWNER      (OWNER),
    .OWNER_VLD  (OWNER_VLD),
    .TIMEOUT_EVT(TIMEOUT_EVT)
  );

  pci_bus_arbiter #(
    .N_MASTERS(8),
    .TIMEOUT  (16),
    .PARK_EN  (1'b0),
    .PARK_ID  (0)
  ) u_dut_np (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_N      (REQ_N),
    .FRAME_N    (FRAME_N),
    .IRDY_N     (IRDY_N),
    .GNT_N      (w_gnt_n_np),
    .OWNER      (w_owner_np),
    .OWNER_VLD  (w_owner_vld_np),
    .TIMEOUT_EVT(w_timeout_evt_np)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_grant(output int gaps);
    gaps = 0;
    for (int k = 0; k < 8 && GNT_N == 8'hFF; k++) begin
      gaps++;
      tick();
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ_N = 8'hFF; FRAME_N = 1'b1; IRDY_N = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps;
    int lowc;
    int exp_ord[6] = '{2, 4, 0, 2, 4, 0};

    // Reset values
    RST = 1'b1; REQ_N = 8'hFF; FRAME_N = 1'b1; IRDY_N = 1'b1;
    tick(); tick();
    chk("rst_gnt",     32'(GNT_N), 32'hFF);
    chk("rst_owner",   32'(OWNER), 32'd0);
    chk("rst_vld",     32'(OWNER_VLD), 32'd0);
    chk("rst_tevt",    32'(TIMEOUT_EVT), 32'd0);
    chk("rst_np_gnt",  32'(w_gnt_n_np), 32'hFF);
    chk("rst_np_own",  32'({w_owner_np, w_owner_vld_np, w_timeout_evt_np}), 32'd0);

    // 1: single request from reset, then ownership
    RST = 1'b0; REQ_N = 8'hFE;
    tick();
    chk("t1_gnt", 32'(GNT_N), 32'hFE);
    FRAME_N = 1'b0;
    tick();
    chk("t1_owner", 32'(OWNER), 32'd0);
    chk("t1_vld",   32'(OWNER_VLD), 32'd1);
    chk("t1_gnt_hold", 32'(GNT_N), 32'hFE);
    FRAME_N = 1'b1; REQ_N = 8'hFF;
    tick();
    chk("t1_drop", 32'(GNT_N), 32'hFF);
    chk("t1_vld_gap", 32'(OWNER_VLD), 32'd1);
    tick();
    chk("t1_vld_end", 32'(OWNER_VLD), 32'd0);

    // 2: round robin among 0,2,4 starting after last owner 0
    REQ_N = 8'hEA;
    for (int t = 0; t < 6; t++) begin
      wait_grant(gaps);
      chk("t2_gap",   32'(gaps != 0), 32'd1);
      chk("t2_order", 32'(GNT_N), 32'(~(8'h01 << exp_ord[t]) & 8'hFF));
      FRAME_N = 1'b0; IRDY_N = 1'b0;
      tick();
      chk("t2_owner", 32'(OWNER), 32'(exp_ord[t]));
      FRAME_N = 1'b1; IRDY_N = 1'b0;
      tick();
      chk("t2_preempt", 32'(GNT_N), 32'hFF);
      FRAME_N = 1'b1; IRDY_N = 1'b1;
      tick();
      chk("t2_vld_end", 32'(OWNER_VLD), 32'd0);
    end

    // 3: unused grant to 3 times out after 16 cycles; 5 wins next
    REQ_N = 8'hD7;
    tick();
    chk("t3_gnt3", 32'(GNT_N), 32'hF7);
    lowc = 0;
    for (int k = 0; k < 40 && GNT_N == 8'hF7; k++) begin
      lowc++;
      chk("t3_no_evt", 32'(TIMEOUT_EVT), 32'd0);
      tick();
    end
    chk("t3_len",  32'(lowc), 32'd16);
    chk("t3_evt",  32'(TIMEOUT_EVT), 32'd1);
    chk("t3_drop", 32'(GNT_N), 32'hFF);
    tick();
    chk("t3_evt_pulse", 32'(TIMEOUT_EVT), 32'd0);
    chk("t3_gap_gnt",   32'(GNT_N), 32'hFF);
    tick();
    chk("t3_gnt5", 32'(GNT_N), 32'hDF);
    REQ_N = 8'hFF;
    tick();
    chk("t3_req_drop", 32'(GNT_N), 32'hFF);
    tick();
    tick();

    // 5: parking on master 0
    chk("t5_park",    32'(GNT_N), 32'hFE);
    chk("t5_np_idle", 32'(w_gnt_n_np), 32'hFF);
    FRAME_N = 1'b0;
    tick();
    chk("t5_park_own", 32'(OWNER), 32'd0);
    chk("t5_park_vld", 32'(OWNER_VLD), 32'd1);
    FRAME_N = 1'b1;
    tick();
    chk("t5_park_rel", 32'(GNT_N), 32'hFF);
    tick();
    tick();
    chk("t5_repark", 32'(GNT_N), 32'hFE);
    REQ_N = 8'hBF;
    tick();
    chk("t5_unpark", 32'(GNT_N), 32'hFF);
    tick();
    chk("t5_idle", 32'(GNT_N), 32'hFF);
    tick();
    chk("t5_gnt6", 32'(GNT_N), 32'hBF);

    // 4: master 4 owns bus, master 2 preempts
    do_reset();
    REQ_N = 8'hEF;
    tick();
    chk("t4_gnt4", 32'(GNT_N), 32'hEF);
    FRAME_N = 1'b0; IRDY_N = 1'b0;
    tick();
    chk("t4_owner", 32'(OWNER), 32'd4);
    REQ_N = 8'hEB;
    tick();
    chk("t4_preempt", 32'(GNT_N), 32'hFF);
    tick();
    tick();
    chk("t4_busy_gnt", 32'(GNT_N), 32'hFF);
    chk("t4_busy_vld", 32'(OWNER_VLD), 32'd1);
    chk("t4_busy_own", 32'(OWNER), 32'd4);
    FRAME_N = 1'b1;
    tick();
    chk("t4_irdy_gnt", 32'(GNT_N), 32'hFF);
    IRDY_N = 1'b1;
    tick();
    chk("t4_idle_gnt", 32'(GNT_N), 32'hFF);
    chk("t4_idle_vld", 32'(OWNER_VLD), 32'd0);
    tick();
    chk("t4_gnt2", 32'(GNT_N), 32'hFB);

    // 6: reset during ownership by master 5
    do_reset();
    REQ_N = 8'hDF;
    tick();
    chk("t6_gnt5", 32'(GNT_N), 32'hDF);
    FRAME_N = 1'b0;
    tick();
    chk("t6_owner", 32'(OWNER), 32'd5);
    RST = 1'b1;
    tick();
    chk("t6_rst_gnt", 32'(GNT_N), 32'hFF);
    chk("t6_rst_vld", 32'(OWNER_VLD), 32'd0);
    RST = 1'b0; FRAME_N = 1'b1; REQ_N = 8'hDD;
    tick();
    chk("t6_gnt1", 32'(GNT_N), 32'hFD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
